// File: rtl/wb_queue_pkg.sv
// wb_pkg: shared widths and the queue entry type for the writeback queue.
package wb_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if: push side (ALU/load results, stall) and register-file write port.
interface wb_queue_if;
  import wb_pkg::*;

  logic                 alu_valid;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [DATA_W-1:0]    alu_data;
  logic                 mem_valid;
  logic [REG_IDX_W-1:0] mem_rd;
  logic [DATA_W-1:0]    mem_data;
  logic                 stall;
  logic                 rf_ld;
  logic [REG_IDX_W-1:0] rf_c;
  logic [DATA_W-1:0]    rf_data;

  // Producer of results / consumer of the RF write port.
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  stall, rf_ld, rf_c, rf_data
  );

  // The queue itself.
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output stall, rf_ld, rf_c, rf_data
  );

endinterface

// File: rtl/wb_queue_fwd_match.sv
// wb_fwd_match: youngest-first search of the queued entries for one read port.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                  entries_i [DEPTH],
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [REG_IDX_W-1:0]       sel_i,
  output logic                       hit_o,
  output logic [DATA_W-1:0]          data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest (head) to youngest; later matches overwrite, so the youngest wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int o = 0; o < DEPTH; o++) begin
      idx = head_i + PW'(o);
      if (valid_i[idx] && (entries_i[idx].rd == sel_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue feeding the single register-file write port.
// Optional feature: define WBQ_FWD_EN to build the per-read-port forwarding lookup;
// otherwise fwd_*_hit/fwd_*_data are tied to zero.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  wb_queue_if.slave                wbq,
  input  logic [REG_IDX_W-1:0]     fwd_a_sel,
  output logic                     fwd_a_hit,
  output logic [DATA_W-1:0]        fwd_a_data,
  input  logic [REG_IDX_W-1:0]     fwd_b_sel,
  output logic                     fwd_b_hit,
  output logic [DATA_W-1:0]        fwd_b_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     entries_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] free_w;
  logic          pop;
  logic          push_mem;
  logic          push_alu;
  logic [PW-1:0] alu_slot;

  // Free space uses the current count: a slot popped this cycle is not reused until next cycle.
  assign free_w = CW'(DEPTH) - count_q;
  assign pop    = (count_q != '0);

  // Admission (mem is older, alu younger; drops are whole entries) and next-state pointers.
  always_comb begin
    push_mem   = 1'b0;
    push_alu   = 1'b0;
    alu_slot   = tail_q;
    overflow_d = overflow_q;
    if (wbq.mem_valid && wbq.alu_valid) begin
      if (free_w >= CW'(2)) begin
        push_mem = 1'b1;
        push_alu = 1'b1;
        alu_slot = tail_q + PW'(1);
      end else if (free_w == CW'(1)) begin
        push_mem   = 1'b1;
        overflow_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (wbq.mem_valid) begin
      if (free_w != '0) push_mem = 1'b1;
      else              overflow_d = 1'b1;
    end else if (wbq.alu_valid) begin
      if (free_w != '0) push_alu = 1'b1;
      else              overflow_d = 1'b1;
    end
    tail_d  = tail_q + PW'(push_mem) + PW'(push_alu);
    head_d  = head_q + PW'(pop);
    count_d = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
  end

  // Pointer, occupancy and sticky-overflow state; reset empties the queue at once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge Clk) begin
    if (push_mem) entries_q[tail_q]   <= '{rd: wbq.mem_rd, data: wbq.mem_data};
    if (push_alu) entries_q[alu_slot] <= '{rd: wbq.alu_rd, data: wbq.alu_data};
  end

  // RF write port is the head entry, gated so it reads zero when empty.
  assign wbq.rf_ld   = pop;
  assign wbq.rf_c    = pop ? entries_q[head_q].rd   : '0;
  assign wbq.rf_data = pop ? entries_q[head_q].data : '0;
  assign wbq.stall   = (count_q > CW'(DEPTH - 2));
  assign count       = count_q;
  assign overflow    = overflow_q;

`ifdef WBQ_FWD_EN
  logic [DEPTH-1:0] valid_w;

  // An entry is occupied when its distance from head is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PW-1:0] age_w;
    assign age_w       = PW'(gi) - head_q;
    assign valid_w[gi] = (CW'(age_w) < count_q);
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
    .entries_i (entries_q),
    .valid_i   (valid_w),
    .head_i    (head_q),
    .sel_i     (fwd_a_sel),
    .hit_o     (fwd_a_hit),
    .data_o    (fwd_a_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
    .entries_i (entries_q),
    .valid_i   (valid_w),
    .head_i    (head_q),
    .sel_i     (fwd_b_sel),
    .hit_o     (fwd_b_hit),
    .data_o    (fwd_b_data)
  );
`else
  logic unused_fwd_sel;
  assign unused_fwd_sel = ^{fwd_a_sel, fwd_b_sel};
  assign fwd_a_hit      = 1'b0;
  assign fwd_a_data     = '0;
  assign fwd_b_hit      = 1'b0;
  assign fwd_b_data     = '0;
`endif

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue that merges ALU results and load data into the register file's single write port. It sits directly upstream of the register file and drives its write-enable, write-select and write-data inputs. Up to DEPTH pending writes are buffered in program order and drained at one per cycle. A per-read-port forwarding lookup returns the youngest pending value for any register that is still queued.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, ≥ 2.

Ports:
- Clk  in  1  rising-edge clock; the only clock.
- Rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  4  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  load result present this cycle.
- mem_rd  in  4  load destination register.
- mem_data  in  32  load data.
- stall  out  1  upstream must hold both valids low.
- rf_ld  out  1  write enable to the register file (RF).
- rf_c  out  4  write select to the register file (C).
- rf_data  out  32  write data to the register file (PC).
- fwd_a_sel  in  4  register index on read port A.
- fwd_a_hit  out  1  a queued write targets fwd_a_sel.
- fwd_a_data  out  32  youngest queued value for fwd_a_sel.
- fwd_b_sel  in  4  register index on read port B.
- fwd_b_hit  out  1  a queued write targets fwd_b_sel.
- fwd_b_data  out  32  youngest queued value for fwd_b_sel.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky flag: a push was dropped.

Reset is asynchronous and active-low on Rst_n. Everything is clocked by Clk.

## Operation
- Storage is a circular buffer of {rd, data} entries with head and tail pointers of width $clog2(DEPTH), which wrap modulo DEPTH.
- Push order within one cycle:
  - mem entry first (older), then alu entry (younger).
  - If both are valid, two entries are written and tail advances by 2.
- Pop:
  - When count ≠ 0, the head entry drives rf_ld=1, rf_c=head.rd, rf_data=head.data.
  - The head is popped on every Clk edge while count ≠ 0.
- Simultaneous push and pop: count_next = count + pushes − pop. A slot freed this cycle is not reusable until the next cycle; free space is computed from the current count.
- Stall rule: stall = (count > DEPTH−2), which guarantees room for a dual push on the next edge.
- Overflow:
  - Any valid arriving while free space is insufficient is dropped whole, never partially written.
  - overflow is set on a drop and cleared only by reset.
  - Two valids with exactly one free slot: the mem entry is kept and the alu entry is dropped.
- Forwarding, per port:
  - Search all occupied entries; the youngest entry whose rd equals sel wins.
  - No match: hit=0, data=0.
  - Incoming (not yet queued) valids are not searched.
- Register 15 gets no special treatment.
- Same-cycle pushes to the same rd: the alu value is younger, so it wins both forwarding and the final register contents.

## Timing
- Reset values: count=0, head=tail=0, rf_ld=0, rf_c=0, rf_data=0, stall=0, overflow=0, fwd_*_hit=0, fwd_*_data=0. Entry contents are don't-care.
- Reset mid-operation: the queue empties immediately and pending writes are lost; rf_ld falls asynchronously.
- rf_* outputs are combinational from the registered head entry and pointers.
- Latency: a write pushed at edge N is committed to the register file at edge N+1 when the queue was empty, and at edge N+1+k with k older entries queued.
- stall, count and overflow are registered-state derived and have no combinational path from the valid inputs.
- fwd_* outputs are combinational from sel and the queue state.

## Configuration
- WBQ_FWD_EN defined: forwarding comparators and priority select are built as described above.
- WBQ_FWD_EN undefined:
  - fwd_*_hit and fwd_*_data are tied to 0 and no match logic is instantiated.
  - fwd_*_sel inputs are ignored.
  - All other behaviour is identical.

## Structure
- Package wb_pkg holds: REG_IDX_W=4, DATA_W=32, typedef wb_entry_t {logic [REG_IDX_W-1:0] rd; logic [DATA_W-1:0] data;}.
- Sub-module wb_fwd_match: a youngest-first priority search over the entry array, valid mask and head/tail. It is instantiated once per read port and only under WBQ_FWD_EN.

## Test plan
- Reset, then check all outputs: every output is 0 while Rst_n=0 and after release.
- Single alu push rd=3, data=0x1234 at edge N: rf_ld=1, rf_c=3, rf_data=0x1234 during cycle N→N+1; count returns to 0 after edge N+1.
- Dual push mem(rd=5, 0xAAAA) and alu(rd=5, 0xBBBB): drain order is 0xAAAA then 0xBBBB; fwd_a_sel=5 gives hit=1, data=0xBBBB until both drain.
- Fill with DEPTH=4 using back-to-back dual pushes: stall rises at count=3, and forcing a further dual push with count=3 gives mem kept, alu dropped, overflow=1 and sticky.
- Pointer wrap: push 10 single entries with staggered gaps; they commit in order with correct rd/data across head/tail wrap.
- Assert Rst_n=0 with count=3: rf_ld falls immediately, count=0, and no further writes issue after release.
